// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer. One input stream is steered to one of four
// single-entry output lanes, chosen by S or by a round-robin pointer, with per-lane drain counters.
module demux4_stream #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] IN,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [1:0]   S,
    input  logic         AUTO,
    output logic [W-1:0] OUT0,
    output logic [W-1:0] OUT1,
    output logic [W-1:0] OUT2,
    output logic [W-1:0] OUT3,
    output logic [3:0]   OUT_VALID,
    input  logic [3:0]   OUT_READY,
    output logic [7:0]   CNT0,
    output logic [7:0]   CNT1,
    output logic [7:0]   CNT2,
    output logic [7:0]   CNT3,
    output logic [1:0]   RR_PTR
);

    // Handshake: a word moves on a port when valid and ready are both high at the rising edge;
    // valid never waits on ready, while ready may depend combinationally on the downstream ready.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t  lane_q [4];
    lane_state_t  lane_d [4];
    logic [W-1:0] data_q [4];
    logic [7:0]   cnt_q  [4];
    logic [1:0]   rr_q;
    logic [1:0]   tgt;
    logic [3:0]   drain;
    logic         accept;

    assign tgt      = AUTO ? rr_q : S;
    // Only the target lane gates the input: a stalled target blocks everything behind it.
    assign IN_READY = (lane_q[tgt] == EMPTY) || OUT_READY[tgt];
    assign accept   = IN_VALID && IN_READY;

    always_comb begin
        drain     = '0;
        OUT_VALID = '0;
        for (int n = 0; n < 4; n++) begin
            lane_d[n]    = lane_q[n];
            drain[n]     = (lane_q[n] == FULL) && OUT_READY[n];
            OUT_VALID[n] = (lane_q[n] == FULL);
            // A refill wins over a drain so a lane can pass one word per cycle.
            if (accept && (tgt == 2'(n))) begin
                lane_d[n] = FULL;
            end else if (drain[n]) begin
                lane_d[n] = EMPTY;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int n = 0; n < 4; n++) begin
                lane_q[n] <= EMPTY;
                data_q[n] <= '0;
                cnt_q[n]  <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                lane_q[n] <= lane_d[n];
                if (accept && (tgt == 2'(n))) begin
                    data_q[n] <= IN;
                end
                if (drain[n]) begin
                    cnt_q[n] <= cnt_q[n] + 8'd1;
                end
            end
            if (accept && AUTO) begin
                rr_q <= rr_q + 2'd1;
            end
        end
    end

    assign OUT0   = data_q[0];
    assign OUT1   = data_q[1];
    assign OUT2   = data_q[2];
    assign OUT3   = data_q[3];
    assign CNT0   = cnt_q[0];
    assign CNT1   = cnt_q[1];
    assign CNT2   = cnt_q[2];
    assign CNT3   = cnt_q[3];
    assign RR_PTR = rr_q;

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: a lane/pointer/counter reference model plus an expected-word
// queue tagged with the destination lane, checked every cycle and in directed scenarios.
module tb_demux4_stream;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   sel;
    logic         auto_mode;
    logic [W-1:0] out0, out1, out2, out3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [7:0]   cnt0, cnt1, cnt2, cnt3;
    logic [1:0]   rr_ptr;

    demux4_stream #(.W(W)) dut (
        .CLK(clk), .RST(rst), .IN(din), .IN_VALID(in_valid), .IN_READY(in_ready),
        .S(sel), .AUTO(auto_mode),
        .OUT0(out0), .OUT1(out1), .OUT2(out2), .OUT3(out3),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .CNT0(cnt0), .CNT1(cnt1), .CNT2(cnt2), .CNT3(cnt3),
        .RR_PTR(rr_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state and scoreboard: each entry is {lane, word}
    logic [3:0]   m_full;
    logic [1:0]   m_rr;
    logic [7:0]   m_cnt [4];
    logic [W+1:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lane_data(input int n);
        case (n)
            0: return out0;
            1: return out1;
            2: return out2;
            default: return out3;
        endcase
    endfunction

    function automatic logic [7:0] lane_cnt(input int n);
        case (n)
            0: return cnt0;
            1: return cnt1;
            2: return cnt2;
            default: return cnt3;
        endcase
    endfunction

    task automatic model_clear();
        m_full = '0;
        m_rr   = '0;
        for (int n = 0; n < 4; n++) m_cnt[n] = '0;
        exp_q.delete();
    endtask

    task automatic pop_lane(input int n);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][W+1:W] == 2'(n)) begin
                check($sformatf("lane%0d_data", n), lane_data(n), exp_q[i][W-1:0]);
                exp_q.delete(i);
                break;
            end
        end
    endtask

    // One clock cycle: inputs are already set (just after a rising edge). Compare at the falling
    // edge, then advance the model through the coming rising edge.
    task automatic tick();
        logic [1:0] t;
        logic       rdy;
        @(negedge clk);
        t   = auto_mode ? m_rr : sel;
        rdy = !m_full[t] || out_ready[t];
        check("in_ready", in_ready, rdy);
        check("rr_ptr", rr_ptr, m_rr);
        check("out_valid", out_valid, m_full);
        for (int n = 0; n < 4; n++) check($sformatf("cnt%0d", n), lane_cnt(n), m_cnt[n]);
        for (int n = 0; n < 4; n++) begin
            if (m_full[n] && out_ready[n]) begin
                pop_lane(n);
                m_full[n] = 1'b0;
                m_cnt[n]  = m_cnt[n] + 8'd1;
            end
        end
        if (in_valid && rdy) begin
            exp_q.push_back({t, din});
            m_full[t] = 1'b1;
            if (auto_mode) m_rr = m_rr + 2'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks the cleared state before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_rr", rr_ptr, 2'd0);
        check("rst_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'd0);
        check("rst_outs", {out0, out1, out2, out3}, 32'd0);
        model_clear();
        rst = 1'b0;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; din = '0; in_valid = 1'b0; sel = '0; auto_mode = 1'b0; out_ready = '0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        tick();

        // reset mid-stream with all four lanes full
        auto_mode = 1'b1; out_ready = 4'b0000; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'h30 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("mid_full", out_valid, 4'b1111);
        do_reset();
        tick();

        // directed routing and back-pressure on the target lane only
        auto_mode = 1'b0; sel = 2'd2; out_ready = 4'b0000; din = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("dir_out2", out2, 8'hA5);
        check("dir_valid", out_valid, 4'b0100);
        check("dir_ready_s2", in_ready, 1'b0);
        sel = 2'd1;
        #1;
        check("dir_ready_s1", in_ready, 1'b1);
        drain_all();

        // round-robin with all consumers ready
        do_reset();
        auto_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'h10 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("rr_wrap", rr_ptr, 2'd0);
        check("rr_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'h02020202);

        // same-lane drain and refill every cycle
        do_reset();
        auto_mode = 1'b0; sel = 2'd3; out_ready = 4'b1000; in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            din = 8'(i);
            tick();
            check("sl_out3", out3, 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("sl_cnt3", cnt3, 8'd5);

        // head-of-line stall: lane 1 full and stalled while the pointer is at 1
        do_reset();
        auto_mode = 1'b1; out_ready = 4'b1101; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 8'h20 + 8'(i);
            tick();
        end
        din = 8'h99;
        repeat (3) tick();
        check("hol_ready", in_ready, 1'b0);
        check("hol_rr_hold", rr_ptr, 2'd1);
        out_ready = 4'b1111;
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        check("hol_rr_adv", rr_ptr, 2'd2);
        check("hol_out1", out1, 8'h99);
        check("hol_valid1", out_valid[1], 1'b1);
        drain_all();

        // counter wrap on lane 0
        do_reset();
        auto_mode = 1'b0; sel = 2'd0; out_ready = 4'b0001; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            din = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("wrap_255", cnt0, 8'd255);
        tick();
        check("wrap_0", cnt0, 8'd0);
        check("wrap_others", {cnt1, cnt2, cnt3}, 24'd0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            auto_mode = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 1'($urandom_range(0, 1));
            din       = 8'($urandom_range(0, 255));
            out_ready = 4'($urandom_range(0, 15));
            tick();
        end
        drain_all();
        check("sb_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/demux4_stream.md
# demux4_stream

Registered 1-to-4 stream demultiplexer: the distribution end of the 4:1 select mux. A single valid/ready input stream is routed to one of four output lanes, chosen either by an explicit 2-bit select `S` or by an internal round-robin pointer. Each lane has a one-entry holding register and an 8-bit delivered-word counter. It sits between a shared producer and four independent consumers.

## Interface
Parameters:
- `W`, default 8: data width.

Ports:
- `CLK` input, 1 bit: clock, rising edge.
- `RST` input, 1 bit: reset. Asynchronous, active-high.
- `IN` input, W bits: input data.
- `IN_VALID` input, 1 bit: input word present.
- `IN_READY` output, 1 bit: block can accept the input word this cycle.
- `S` input, 2 bits: lane select. Sampled only when `AUTO`=0.
- `AUTO` input, 1 bit: 1 selects round-robin routing; 0 selects `S`-directed routing.
- `OUT0`..`OUT3` output, W bits each: lane data.
- `OUT_VALID` output, 4 bits: per-lane valid.
- `OUT_READY` input, 4 bits: per-lane consumer ready.
- `CNT0`..`CNT3` output, 8 bits each: per-lane delivered-word count.
- `RR_PTR` output, 2 bits: current round-robin pointer.

## Operation
- Target lane `t` = `AUTO` ? `RR_PTR` : `S`. It is combinational and evaluated every cycle.
- Each lane has two states:
  - EMPTY: `OUT_VALID[n]`=0.
  - FULL: `OUT_VALID[n]`=1; `OUTn` holds the word.
- Lane drain: `OUT_VALID[n] && OUT_READY[n]`.
- `IN_READY` = !`OUT_VALID[t]` || `OUT_READY[t]`. It is combinational and depends only on the target lane.
- Input accept: `IN_VALID && IN_READY`. On accept, lane `t` loads `IN` and is FULL the next cycle.
- A FULL lane that drains and is not refilled becomes EMPTY.
- Non-target lanes never change their data and drain independently. Any number of lanes may drain in the same cycle.
- Holding registers change only on accept. `OUTn` keeps its last value after draining.
- Drain and refill of the same lane in one cycle: the old word is delivered and the new word is loaded. This gives one word per cycle sustained on a lane.
- `RR_PTR` increments (mod 4, 3→0) on each accept while `AUTO`=1. It is frozen while `AUTO`=0.
- A change of `AUTO` or `S` takes effect on the next evaluation of `t`. There is no flush, and words already held stay in their lanes.
- `CNTn` increments on each lane-n drain and wraps 255→0.
- Back-pressure: if lane `t` is FULL and `OUT_READY[t]`=0, `IN_READY`=0. A stalled target lane stalls the whole input, even when other lanes are free. There is no reordering or skip-ahead.

## Timing
- Latency: a word accepted in cycle k is visible on `OUTt` with `OUT_VALID[t]`=1 in cycle k+1.
- Throughput: one word per cycle total.
- Reset values: `OUT_VALID`=0, `OUT0`..`OUT3`=0, `CNT0`..`CNT3`=0, `RR_PTR`=0.
- `IN_READY` is 1 after reset because all lanes are EMPTY.
- `RST` asserted mid-operation clears everything immediately. Held words are discarded and not counted.
- The first edge after `RST` deasserts behaves as a normal cycle.
- `IN_VALID`=0 has no effect on any state except lane drains.
- No combinational path from `IN` or `IN_VALID` to any output. `IN_READY` is combinational from `OUT_READY`, `AUTO`, `S`, and the lane state.

## Test plan
- **Reset mid-stream:** fill all four lanes, then pulse `RST`. Required: `OUT_VALID`=0000, all `CNTn`=0, `RR_PTR`=0, and `IN_READY`=1 in the same cycle.
- **Directed routing:** `AUTO`=0, `S`=2, `IN`=0xA5 valid for one cycle, `OUT_READY`=0000. Required next cycle: `OUT2`=0xA5, `OUT_VALID`=0100, `IN_READY`=0 while `S`=2 stays, `IN_READY`=1 when `S`=1.
- **Round-robin:** `AUTO`=1, all `OUT_READY`=1, stream 0x10..0x17 over 8 cycles. Required: lane n receives 0x10+n and 0x14+n, `RR_PTR` returns to 0, each `CNTn`=2.
- **Same-lane drain and refill:** `AUTO`=0, `S`=3, `OUT_READY[3]`=1, 5 back-to-back words 1..5. Required: `IN_READY` stays 1, `OUT3` shows 1..5 on consecutive cycles, `CNT3`=5.
- **Head-of-line stall:** `AUTO`=1, lane 1 FULL with `OUT_READY[1]`=0, `RR_PTR`=1. Required: `IN_READY`=0 and `RR_PTR` holds. After `OUT_READY[1]` rises for one cycle, the pending word is accepted into lane 1 and `RR_PTR`=2.
- **Counter wrap:** drive 256 drains on lane 0. Required: `CNT0` goes 255→0 and the other counters are unaffected.
